// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: FSM state encoding and baud-timing helpers.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } rx_state_e;

   function automatic int clks_per_bit(input int clk_freq, input int baud);
      return clk_freq / baud;
   endfunction

   function automatic int half_bit(input int clk_freq, input int baud);
      return clks_per_bit(clk_freq, baud) / 2;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input; both flops reset to RST_VAL.
module sync_2ff #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   // NOTE: sequential state always uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= RST_VAL;
         sync_q <= RST_VAL;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling, glitch rejection and sticky status flags.
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLK_FREQ = 50_000_000,
   parameter int BAUD     = 115200
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx,
   output logic [7:0] rx_data,
   output logic       rx_flag,
   input  logic       rx_flag_clr,
   output logic       framing_err,
   output logic       overrun,
   output logic       rx_busy
);

   localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
   localparam int HALF_BIT     = half_bit(CLK_FREQ, BAUD);
   localparam int CNT_W        = $clog2(CLKS_PER_BIT);

   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT - 1);

   logic rx_s;

   rx_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_idx_q, bit_idx_d;
   logic [7:0]       shift_q, shift_d;
   logic [7:0]       rx_data_q, rx_data_d;
   logic             rx_flag_q, rx_flag_d;
   logic             framing_err_q, framing_err_d;
   logic             overrun_q, overrun_d;
   logic             wait_high_q, wait_high_d;
   logic             byte_ok;
   logic             frame_bad;

   sync_2ff #(
      .RST_VAL (1'b1)
   ) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d_i   (rx),
      .q_o   (rx_s)
   );

   // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      bit_idx_d   = bit_idx_q;
      shift_d     = shift_q;
      wait_high_d = wait_high_q & ~rx_s;
      byte_ok     = 1'b0;
      frame_bad   = 1'b0;

      unique case (state_q)
         IDLE: begin
            // After a framing error the line must go high again before a new start is accepted.
            if (!rx_s && !wait_high_q) begin
               state_d = START;
               cnt_d   = '0;
            end
         end
         START: begin
            if (cnt_q == CNT_HALF) begin
               cnt_d     = '0;
               bit_idx_d = '0;
               state_d   = rx_s ? IDLE : DATA;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DATA: begin
            if (cnt_q == CNT_FULL) begin
               cnt_d     = '0;
               shift_d   = {rx_s, shift_q[7:1]};
               bit_idx_d = bit_idx_q + 3'd1;
               if (bit_idx_q == 3'd7) begin
                  state_d = STOP;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         STOP: begin
            if (cnt_q == CNT_FULL) begin
               cnt_d   = '0;
               state_d = IDLE;
               if (rx_s) begin
                  byte_ok = 1'b1;
               end else begin
                  frame_bad   = 1'b1;
                  wait_high_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      // A new set event takes priority over a coincident clear.
      rx_data_d     = byte_ok ? shift_q : rx_data_q;
      rx_flag_d     = byte_ok | (rx_flag_q & ~rx_flag_clr);
      framing_err_d = frame_bad | (framing_err_q & ~rx_flag_clr);
      overrun_d     = (byte_ok & rx_flag_q) | (overrun_q & ~rx_flag_clr);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         bit_idx_q     <= '0;
         shift_q       <= '0;
         rx_data_q     <= '0;
         rx_flag_q     <= 1'b0;
         framing_err_q <= 1'b0;
         overrun_q     <= 1'b0;
         wait_high_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         bit_idx_q     <= bit_idx_d;
         shift_q       <= shift_d;
         rx_data_q     <= rx_data_d;
         rx_flag_q     <= rx_flag_d;
         framing_err_q <= framing_err_d;
         overrun_q     <= overrun_d;
         wait_high_q   <= wait_high_d;
      end
   end

   assign rx_data     = rx_data_q;
   assign rx_flag     = rx_flag_q;
   assign framing_err = framing_err_q;
   assign overrun     = overrun_q;
   assign rx_busy     = (state_q != IDLE);

endmodule
